kyber_encrypt_seq: RTL

- Baby-Kyber encryptor for the Q=17, N=4 (ring Z_q[x]/(x^4+1)), K=2 parameter set; the transmitting end of the decrypt path.
- Takes public key (A, t), randomness r, errors e1/e2 and a 4-bit message, and produces ciphertext (u, v) in the exact array layout the decrypt block consumes.
- Uses one multiply-accumulate unit, time-multiplexed over 96 cycles, under a start/done handshake.

---
 rtl/kyber_encrypt_seq_if.sv | 29 ++
 rtl/kyber_encrypt_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/kyber_encrypt_seq_if.sv
// Port bundle for kyber_encrypt_seq: run enable, start/done handshake,
// public-key and noise operands in, ciphertext and status out.
interface kyber_encrypt_seq_if;
  // Handshake: start is sampled only while the engine is idle and enable=1.
  // busy is high while a job is in flight. done pulses for one cycle when
  // ciphertext updates, and ciphertext then stays stable until the next done.
  logic              enable;
  logic              start;
  logic signed [31:0] pk_a       [0:1][0:1][0:3];
  logic signed [31:0] pk_t       [0:1][0:3];
  logic signed [31:0] r_vec      [0:1][0:3];
  logic signed [31:0] e1_vec     [0:1][0:3];
  logic signed [31:0] e2_poly    [0:3];
  logic [3:0]        message;
  logic signed [31:0] ciphertext [0:1][0:1][0:3];
  logic              busy;
  logic              done;
  logic              bound_err;

  modport master (
    output enable, start, pk_a, pk_t, r_vec, e1_vec, e2_poly, message,
    input  ciphertext, busy, done, bound_err
  );

  modport slave (
    input  enable, start, pk_a, pk_t, r_vec, e1_vec, e2_poly, message,
    output ciphertext, busy, done, bound_err
  );
endinterface

// File: rtl/kyber_encrypt_seq.sv
// Baby-Kyber (Q=17, N=4, K=2) encryptor on one time-multiplexed MAC.
// Optional noise bound check enabled by defining KYBER_ENC_BOUND_CHK_EN.
module kyber_encrypt_seq (
  input  logic               clk,
  input  logic               rst_n,
  kyber_encrypt_seq_if.slave bus,
  output logic [1:0]         dbg_state
);
  localparam int Q     = 17;
  localparam int DELTA = 9;
`ifdef KYBER_ENC_BOUND_CHK_EN
  localparam int ETA   = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [4:0]         a_q   [0:1][0:1][0:3];
  logic [4:0]         a_d   [0:1][0:1][0:3];
  logic [4:0]         t_q   [0:1][0:3];
  logic [4:0]         t_d   [0:1][0:3];
  logic [4:0]         r_q   [0:1][0:3];
  logic [4:0]         r_d   [0:1][0:3];
  logic [4:0]         e1_q  [0:1][0:3];
  logic [4:0]         e1_d  [0:1][0:3];
  logic [4:0]         e2_q  [0:3];
  logic [4:0]         e2_d  [0:3];
  logic [3:0]         msg_q, msg_d;
  logic signed [31:0] acc_q [0:2][0:3];
  logic signed [31:0] acc_d [0:2][0:3];
  logic [4:0]         ct_q  [0:2][0:3];
  logic [4:0]         ct_d  [0:2][0:3];
  logic               done_q, done_d;
`ifdef KYBER_ENC_BOUND_CHK_EN
  logic               bnd_q, bnd_d;
`endif

  function automatic logic [4:0] modq(input logic signed [31:0] x);
    logic signed [31:0] m;
    m = x % Q;
    if (m < 0) m = m + Q;
    return m[4:0];
  endfunction

`ifdef KYBER_ENC_BOUND_CHK_EN
  function automatic logic out_of_bound(input logic signed [31:0] x);
    return (x < -ETA) || (x > ETA);
  endfunction
`endif

  // Counter decode: cnt = {p[1:0], k, i[1:0], j[1:0]}
  logic [1:0]         sel_p, sel_i, sel_j, sel_b;
  logic               sel_k;
  logic [4:0]         op_a, op_b;
  logic [9:0]         prod;
  logic signed [31:0] prod_s;

  always_comb begin
    sel_p  = cnt_q[6:5];
    sel_k  = cnt_q[4];
    sel_i  = cnt_q[3:2];
    sel_j  = cnt_q[1:0];
    sel_b  = sel_i - sel_j;
    // u uses the transpose of A; v uses t
    op_a   = (sel_p == 2'd2) ? t_q[sel_k][sel_j] : a_q[sel_k][sel_p[0]][sel_j];
    op_b   = r_q[sel_k][sel_b];
    prod   = {5'd0, op_a} * {5'd0, op_b};
    prod_s = $signed({22'd0, prod});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    t_d     = t_q;
    r_d     = r_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    msg_d   = msg_q;
    acc_d   = acc_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
`ifdef KYBER_ENC_BOUND_CHK_EN
    bnd_d   = bnd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable && bus.start) begin
`ifdef KYBER_ENC_BOUND_CHK_EN
          bnd_d = 1'b0;
`endif
          for (int x = 0; x < 2; x++) begin
            for (int c = 0; c < 4; c++) begin
              a_d[x][0][c] = modq(bus.pk_a[x][0][c]);
              a_d[x][1][c] = modq(bus.pk_a[x][1][c]);
              t_d[x][c]    = modq(bus.pk_t[x][c]);
              r_d[x][c]    = modq(bus.r_vec[x][c]);
              e1_d[x][c]   = modq(bus.e1_vec[x][c]);
`ifdef KYBER_ENC_BOUND_CHK_EN
              if (out_of_bound(bus.r_vec[x][c]) || out_of_bound(bus.e1_vec[x][c]))
                bnd_d = 1'b1;
`endif
            end
          end
          for (int c = 0; c < 4; c++) begin
            e2_d[c] = modq(bus.e2_poly[c]);
`ifdef KYBER_ENC_BOUND_CHK_EN
            if (out_of_bound(bus.e2_poly[c])) bnd_d = 1'b1;
`endif
            for (int p = 0; p < 3; p++) acc_d[p][c] = '0;
          end
          msg_d   = bus.message;
          cnt_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (bus.enable) begin
          // x^4 = -1: terms whose index wrapped past the ring degree subtract
          if (sel_p != 2'd3) begin
            if (sel_j <= sel_i)
              acc_d[sel_p][sel_i] = acc_q[sel_p][sel_i] + prod_s;
            else
              acc_d[sel_p][sel_i] = acc_q[sel_p][sel_i] - prod_s;
          end
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd95) state_d = FINAL;
        end
      end
      FINAL: begin
        if (bus.enable) begin
          for (int c = 0; c < 4; c++) begin
            ct_d[0][c] = modq(acc_q[0][c] + $signed({27'd0, e1_q[0][c]}));
            ct_d[1][c] = modq(acc_q[1][c] + $signed({27'd0, e1_q[1][c]}));
            ct_d[2][c] = modq(acc_q[2][c] + $signed({27'd0, e2_q[c]})
                              + (msg_q[c] ? DELTA : 0));
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '{default: '0};
      t_q     <= '{default: '0};
      r_q     <= '{default: '0};
      e1_q    <= '{default: '0};
      e2_q    <= '{default: '0};
      msg_q   <= '0;
      acc_q   <= '{default: '0};
      ct_q    <= '{default: '0};
      done_q  <= 1'b0;
`ifdef KYBER_ENC_BOUND_CHK_EN
      bnd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      t_q     <= t_d;
      r_q     <= r_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      msg_q   <= msg_d;
      acc_q   <= acc_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
`ifdef KYBER_ENC_BOUND_CHK_EN
      bnd_q   <= bnd_d;
`endif
    end
  end

  // Layout expected by the decrypt block: [0][0]=u0, [0][1]=u1, [1][0]=v
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      bus.ciphertext[0][0][c] = $signed({27'd0, ct_q[0][c]});
      bus.ciphertext[0][1][c] = $signed({27'd0, ct_q[1][c]});
      bus.ciphertext[1][0][c] = $signed({27'd0, ct_q[2][c]});
      bus.ciphertext[1][1][c] = '0;
    end
  end

  assign bus.busy  = (state_q == MAC) || (state_q == FINAL);
  assign bus.done  = done_q;
`ifdef KYBER_ENC_BOUND_CHK_EN
  assign bus.bound_err = done_q & bnd_q;
`else
  assign bus.bound_err = 1'b0;
`endif
  assign dbg_state = state_q;

endmodule
